pixel_iterator: RTL and testbench
=================================

# pixel_iterator

Bounding-box traversal stage that sits directly upstream of the edge engine. It accepts one triangle, given as three signed screen-space vertices, through a start handshake. It computes the triangle's axis-aligned bounding box clipped to the screen, then emits every pixel coordinate in the box in raster order, one per cycle, with a downstream stall. The latched vertices are held on dedicated outputs so the edge engine sees them constant for the whole traversal.

## Interface

Parameters:
- `SCREEN_W`, default 320: screen width in pixels; valid x range is 0..SCREEN_W-1.
- `SCREEN_H`, default 240: screen height in pixels; valid y range is 0..SCREEN_H-1.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_start`, in, 1: triangle request; sampled only in IDLE.
- `i_x0, i_y0, i_x1, i_y1, i_x2, i_y2`, in, 16 each, signed: vertex coordinates; sampled on start acceptance.
- `i_ready`, in, 1: downstream can take a pixel this cycle.
- `o_x0 .. o_y2`, out, 16 each, signed: latched vertices, stable from acceptance until the next acceptance.
- `o_p_x, o_p_y`, out, 16 each, signed: current pixel coordinate.
- `o_valid`, out, 1: `o_p_x`/`o_p_y` hold a real pixel.
- `o_busy`, out, 1: triangle in progress; high from the cycle after acceptance through the DONE cycle.
- `o_done`, out, 1: one-cycle pulse when traversal completes.

## Operation

State machine: IDLE → SETUP → SCAN → DONE → IDLE.
- **IDLE:**
  - On `i_start`=1, latch all six vertex inputs into the `o_x*`/`o_y*` registers and go to SETUP.
  - Otherwise remain in IDLE.
- **SETUP:**
  - Compute `bx_min = max(min(x0,x1,x2), 0)` and `bx_max = min(max(x0,x1,x2), SCREEN_W-1)`.
  - Compute `by_min` and `by_max` the same way, using y and SCREEN_H-1.
  - All comparisons are signed 16-bit.
  - If `bx_min > bx_max` or `by_min > by_max` (box fully offscreen), go to DONE and emit no pixels.
  - Otherwise set `o_p_x = bx_min`, `o_p_y = by_min`, `o_valid = 1`, and go to SCAN.
- **SCAN:** a pixel transfers on any cycle with `o_valid && i_ready`. On a transfer:
  - If `o_p_x < bx_max`, increment `o_p_x`.
  - Else, if `o_p_y < by_max`, set `o_p_x = bx_min` and increment `o_p_y`.
  - Else (last pixel), clear `o_valid` and go to DONE.
- **Stall:** while `i_ready`=0, `o_p_x`, `o_p_y` and `o_valid` hold unchanged.
- **DONE:** `o_done` = 1 for exactly one cycle, then go to IDLE.
- **Start while busy:** `i_start` in SETUP, SCAN or DONE is ignored and not queued.
- **Degenerate triangles:** collinear or coincident vertices are not special-cased; the box is still traversed and the edge engine rejects the pixels.
- **Pixel count:** `(bx_max-bx_min+1)*(by_max-by_min+1)`.

## Timing

- **Reset values:**
  - state = IDLE
  - `o_valid`, `o_busy`, `o_done` = 0
  - `o_p_x`, `o_p_y` = 0
  - all `o_x*`/`o_y*` = 0
  - bounding-box registers = 0
- **Reset mid-traversal:** the asynchronous clear takes effect immediately. No `o_done` pulse is produced, and the first `i_start` after reset release is accepted normally.
- **Acceptance and first pixel:** `i_start` is sampled at edge T. SETUP occupies T..T+1, and the first pixel is valid after edge T+1.
- **Throughput:** with `i_ready` held high, N pixels occupy N consecutive cycles.
- **Completion:** `o_done` is high in the cycle after the last transfer. `o_busy` falls in the following cycle, and a new `i_start` is accepted in that IDLE cycle or later.
- **Empty box:** `o_done` is high in the cycle after SETUP, i.e. 2 cycles after acceptance, with zero `o_valid` cycles.
- **Combinational paths:** `o_valid` does not depend combinationally on `i_ready`. All outputs are registered.

## Test plan

- **Basic traversal:** triangle (0,0),(3,0),(0,2) with `i_ready`=1.
  - Expect 12 pixels in raster order: (0,0),(1,0),(2,0),(3,0),(0,1),…,(3,2).
  - First pixel 2 cycles after the start edge; `o_done` one cycle after (3,2).
  - `o_x*`/`o_y*` stable throughout.
- **Downstream stall:** same triangle, `i_ready` low for 3 cycles while (2,0) is presented.
  - (2,0) holds for 3 extra cycles and no pixel is skipped or duplicated; 12 transfers total.
- **Clipping:** triangle (-5,-5),(2,-5),(-5,1) with `SCREEN_W`=320, `SCREEN_H`=240.
  - Box clips to x 0..2, y 0..1; expect 6 pixels starting at (0,0).
  - Second case: vertices up to (330,250) clip to `bx_max`=319, `by_max`=239.
- **Fully offscreen:** triangle (-10,-10),(-2,-3),(-7,-1).
  - No `o_valid` cycles; `o_done` 2 cycles after acceptance; `o_busy` falls the next cycle.
- **Start while busy:** assert `i_start` with new vertices during SCAN.
  - Ignored: the pixel sequence and the `o_x*` values are unchanged.
  - A start asserted in the IDLE cycle after `o_done` is accepted.
- **Reset mid-scan:** assert `i_rst_n`=0 asynchronously between clock edges during SCAN.
  - All outputs are 0 immediately, with no `o_done` pulse.
  - A subsequent start traverses correctly from (`bx_min`,`by_min`).

Source files
------------

// File: rtl/pixel_iterator.sv
// pixel_iterator: latches one triangle, clips its bounding box to the screen,
// and walks every box pixel in raster order behind a valid/ready handshake.
module pixel_iterator #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic signed [15:0] i_x0,
  input  logic signed [15:0] i_y0,
  input  logic signed [15:0] i_x1,
  input  logic signed [15:0] i_y1,
  input  logic signed [15:0] i_x2,
  input  logic signed [15:0] i_y2,
  input  logic               i_ready,
  output logic signed [15:0] o_x0,
  output logic signed [15:0] o_y0,
  output logic signed [15:0] o_x1,
  output logic signed [15:0] o_y1,
  output logic signed [15:0] o_x2,
  output logic signed [15:0] o_y2,
  output logic signed [15:0] o_p_x,
  output logic signed [15:0] o_p_y,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic signed [15:0] W_XLIM = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] W_YLIM = 16'(SCREEN_H - 1);

  function automatic logic signed [15:0] smin(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [15:0] smax(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_t r_state;
  state_t w_next;

  logic signed [15:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic signed [15:0] r_bx_min, r_bx_max, r_by_min, r_by_max;
  logic signed [15:0] r_p_x, r_p_y;
  logic               r_valid, r_busy, r_done;

  logic signed [15:0] w_bx_min, w_bx_max, w_by_min, w_by_max;
  logic               w_empty;
  logic               w_xfer;
  logic               w_x_more;
  logic               w_y_more;
  logic               w_accept;

  assign w_bx_min = smax(smin(smin(r_x0, r_x1), r_x2), 16'sd0);
  assign w_bx_max = smin(smax(smax(r_x0, r_x1), r_x2), W_XLIM);
  assign w_by_min = smax(smin(smin(r_y0, r_y1), r_y2), 16'sd0);
  assign w_by_max = smin(smax(smax(r_y0, r_y1), r_y2), W_YLIM);
  assign w_empty  = (w_bx_min > w_bx_max) || (w_by_min > w_by_max);

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_xfer   = r_valid && i_ready;
  assign w_x_more = r_p_x < r_bx_max;
  assign w_y_more = r_p_y < r_by_max;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_SETUP;
      S_SETUP: w_next = w_empty ? S_DONE : S_SCAN;
      S_SCAN:  if (w_xfer && !w_x_more && !w_y_more) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Vertex latch, held until the next accepted triangle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0 <= '0; r_y0 <= '0;
      r_x1 <= '0; r_y1 <= '0;
      r_x2 <= '0; r_y2 <= '0;
    end else if (w_accept) begin
      r_x0 <= i_x0; r_y0 <= i_y0;
      r_x1 <= i_x1; r_y1 <= i_y1;
      r_x2 <= i_x2; r_y2 <= i_y2;
    end
  end

  // Clipped bounding box, captured once in SETUP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bx_min <= '0; r_bx_max <= '0;
      r_by_min <= '0; r_by_max <= '0;
    end else if (r_state == S_SETUP) begin
      r_bx_min <= w_bx_min; r_bx_max <= w_bx_max;
      r_by_min <= w_by_min; r_by_max <= w_by_max;
    end
  end

  // Raster walker: seed in SETUP, advance on each transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_x   <= '0;
      r_p_y   <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_SETUP) begin
      if (!w_empty) begin
        r_p_x   <= w_bx_min;
        r_p_y   <= w_by_min;
        r_valid <= 1'b1;
      end
    end else if (r_state == S_SCAN && w_xfer) begin
      if (w_x_more) begin
        r_p_x <= r_p_x + 16'sd1;
      end else if (w_y_more) begin
        r_p_x <= r_bx_min;
        r_p_y <= r_p_y + 16'sd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Busy spans SETUP..DONE; done pulses on entry to DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
      if (w_accept)                r_busy <= 1'b1;
      else if (r_state == S_DONE)  r_busy <= 1'b0;
    end
  end

  assign o_x0    = r_x0;
  assign o_y0    = r_y0;
  assign o_x1    = r_x1;
  assign o_y1    = r_y1;
  assign o_x2    = r_x2;
  assign o_y2    = r_y2;
  assign o_p_x   = r_p_x;
  assign o_p_y   = r_p_y;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_pixel_iterator.sv
// tb_pixel_iterator: directed scenarios for the bounding-box pixel walker.
// Expected sequences are regenerated from hand-derived clipped boxes.
module tb_pixel_iterator;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_ready = 1'b1;
  logic signed [15:0] i_x0 = '0, i_y0 = '0;
  logic signed [15:0] i_x1 = '0, i_y1 = '0;
  logic signed [15:0] i_x2 = '0, i_y2 = '0;

  logic signed [15:0] o_x0, o_y0, o_x1, o_y1, o_x2, o_y2;
  logic signed [15:0] o_p_x, o_p_y;
  logic o_valid, o_busy, o_done;

  pixel_iterator #(.SCREEN_W(320), .SCREEN_H(240)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1),
    .i_x2(i_x2), .i_y2(i_y2), .i_ready(i_ready),
    .o_x0(o_x0), .o_y0(o_y0), .o_x1(o_x1), .o_y1(o_y1),
    .o_x2(o_x2), .o_y2(o_y2), .o_p_x(o_p_x), .o_p_y(o_p_y),
    .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  int q_x[$];
  int q_y[$];
  int valid_cycles;
  int first_valid;
  int done_cyc;
  bit done_seen;
  bit vert_changed;
  bit hold_bad;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_tri(input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2);
    i_x0 = 16'(x0); i_y0 = 16'(y0);
    i_x1 = 16'(x1); i_y1 = 16'(y1);
    i_x2 = 16'(x2); i_y2 = 16'(y2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Observe one traversal from the SETUP cycle (cyc 0) until o_done.
  task automatic collect(input int stall_at, input int stall_len,
                         input bit inject);
    logic [95:0] snap;
    int k = 0;
    int stalled = 0;
    int cyc = 0;
    int hx = -1;
    int hy = -1;
    q_x.delete();
    q_y.delete();
    valid_cycles = 0;
    first_valid = -1;
    done_cyc = -1;
    done_seen = 1'b0;
    vert_changed = 1'b0;
    hold_bad = 1'b0;
    snap = {o_x0, o_y0, o_x1, o_y1, o_x2, o_y2};
    while (cyc < 2000 && !done_seen) begin
      if (o_done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
      end else begin
        if (o_valid) begin
          valid_cycles++;
          if (first_valid < 0) first_valid = cyc;
        end
        if (stalled > 0 && k == stall_at &&
            (int'(o_p_x) != hx || int'(o_p_y) != hy)) hold_bad = 1'b1;
        if (stall_len > 0 && k == stall_at && stalled < stall_len && o_valid) begin
          hx = int'(o_p_x);
          hy = int'(o_p_y);
          i_ready = 1'b0;
          stalled++;
        end else begin
          i_ready = 1'b1;
        end
        if (inject && cyc == 4) begin
          i_x0 = 16'sd50; i_y0 = 16'sd60; i_x1 = 16'sd70;
          i_y1 = 16'sd80; i_x2 = 16'sd90; i_y2 = 16'sd99;
          i_start = 1'b1;
        end else begin
          i_start = 1'b0;
        end
        if (o_valid && i_ready) begin
          q_x.push_back(int'(o_p_x));
          q_y.push_back(int'(o_p_y));
          k++;
        end
        if ({o_x0, o_y0, o_x1, o_y1, o_x2, o_y2} !== snap) vert_changed = 1'b1;
        tick();
        cyc++;
      end
    end
    i_ready = 1'b1;
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({o_p_x, o_p_y, o_valid, o_busy, o_done} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_outs: got %h want 0",
               {o_p_x, o_p_y, o_valid, o_busy, o_done});
    end
    n_checks++;
    if ({o_x0, o_y0, o_x1, o_y1, o_x2, o_y2} !== 96'd0) begin
      n_errors++;
      $display("FAIL reset_verts: got %h want 0",
               {o_x0, o_y0, o_x1, o_y1, o_x2, o_y2});
    end
  endtask

  task automatic test_basic;
    int idx = 0;
    start_tri(0, 0, 3, 0, 0, 2);
    n_checks++;
    if ({o_busy, o_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL basic_setup: busy,valid got %b want 10", {o_busy, o_valid});
    end
    collect(-1, 0, 1'b0);
    n_checks++;
    if (first_valid != 1) begin
      n_errors++;
      $display("FAIL basic_first: got cyc %0d want 1", first_valid);
    end
    n_checks++;
    if (q_x.size() != 12) begin
      n_errors++;
      $display("FAIL basic_count: got %0d want 12", q_x.size());
    end
    for (int y = 0; y <= 2; y++) begin
      for (int x = 0; x <= 3; x++) begin
        int gx = (idx < q_x.size()) ? q_x[idx] : -999;
        int gy = (idx < q_y.size()) ? q_y[idx] : -999;
        n_checks++;
        if (gx != x || gy != y) begin
          n_errors++;
          $display("FAIL basic_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   idx, gx, gy, x, y);
        end
        idx++;
      end
    end
    n_checks++;
    if (!done_seen || done_cyc != 13) begin
      n_errors++;
      $display("FAIL basic_done: got cyc %0d want 13", done_cyc);
    end
    n_checks++;
    if (vert_changed || o_x1 !== 16'sd3 || o_y2 !== 16'sd2) begin
      n_errors++;
      $display("FAIL basic_verts: changed=%0d x1=%0d y2=%0d want 0,3,2",
               vert_changed, o_x1, o_y2);
    end
    n_checks++;
    if ({o_busy, o_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL basic_done_busy: busy,valid got %b want 10",
               {o_busy, o_valid});
    end
    tick();
    n_checks++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_idle: busy,done got %b want 00", {o_busy, o_done});
    end
  endtask

  task automatic test_stall;
    int idx = 0;
    start_tri(0, 0, 3, 0, 0, 2);
    collect(2, 3, 1'b0);
    n_checks++;
    if (hold_bad || valid_cycles != 15) begin
      n_errors++;
      $display("FAIL stall_hold: hold_bad=%0d valid_cycles=%0d want 0,15",
               hold_bad, valid_cycles);
    end
    n_checks++;
    if (q_x.size() != 12 || done_cyc != 16) begin
      n_errors++;
      $display("FAIL stall_count: got %0d xfers done@%0d want 12 done@16",
               q_x.size(), done_cyc);
    end
    for (int y = 0; y <= 2; y++) begin
      for (int x = 0; x <= 3; x++) begin
        int gx = (idx < q_x.size()) ? q_x[idx] : -999;
        int gy = (idx < q_y.size()) ? q_y[idx] : -999;
        n_checks++;
        if (gx != x || gy != y) begin
          n_errors++;
          $display("FAIL stall_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   idx, gx, gy, x, y);
        end
        idx++;
      end
    end
    tick();
  endtask

  task automatic test_clip;
    int idx = 0;
    start_tri(-5, -5, 2, -5, -5, 1);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (q_x.size() != 6 || done_cyc != 7) begin
      n_errors++;
      $display("FAIL clip1_count: got %0d done@%0d want 6 done@7",
               q_x.size(), done_cyc);
    end
    for (int y = 0; y <= 1; y++) begin
      for (int x = 0; x <= 2; x++) begin
        int gx = (idx < q_x.size()) ? q_x[idx] : -999;
        int gy = (idx < q_y.size()) ? q_y[idx] : -999;
        n_checks++;
        if (gx != x || gy != y) begin
          n_errors++;
          $display("FAIL clip1_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   idx, gx, gy, x, y);
        end
        idx++;
      end
    end
    tick();
    idx = 0;
    start_tri(300, 200, 330, 210, 310, 250);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (q_x.size() != 800 || done_cyc != 801) begin
      n_errors++;
      $display("FAIL clip2_count: got %0d done@%0d want 800 done@801",
               q_x.size(), done_cyc);
    end
    for (int y = 200; y <= 239; y++) begin
      for (int x = 300; x <= 319; x++) begin
        int gx = (idx < q_x.size()) ? q_x[idx] : -999;
        int gy = (idx < q_y.size()) ? q_y[idx] : -999;
        n_checks++;
        if (gx != x || gy != y) begin
          n_errors++;
          $display("FAIL clip2_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   idx, gx, gy, x, y);
        end
        idx++;
      end
    end
    tick();
  endtask

  task automatic test_offscreen;
    start_tri(-10, -10, -2, -3, -7, -1);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (valid_cycles != 0 || !done_seen || done_cyc != 1) begin
      n_errors++;
      $display("FAIL off_done: valid_cycles=%0d done@%0d want 0 done@1",
               valid_cycles, done_cyc);
    end
    tick();
    n_checks++;
    if ({o_busy, o_done, o_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL off_idle: busy,done,valid got %b want 000",
               {o_busy, o_done, o_valid});
    end
  endtask

  task automatic test_start_busy;
    int idx = 0;
    start_tri(0, 0, 3, 0, 0, 2);
    collect(-1, 0, 1'b1);
    n_checks++;
    if (vert_changed || q_x.size() != 12 || done_cyc != 13) begin
      n_errors++;
      $display("FAIL busy_ignore: changed=%0d xfers=%0d done@%0d want 0,12,13",
               vert_changed, q_x.size(), done_cyc);
    end
    for (int y = 0; y <= 2; y++) begin
      for (int x = 0; x <= 3; x++) begin
        int gx = (idx < q_x.size()) ? q_x[idx] : -999;
        int gy = (idx < q_y.size()) ? q_y[idx] : -999;
        n_checks++;
        if (gx != x || gy != y) begin
          n_errors++;
          $display("FAIL busy_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   idx, gx, gy, x, y);
        end
        idx++;
      end
    end
    tick();
    start_tri(1, 1, 2, 1, 1, 2);
    n_checks++;
    if (o_busy !== 1'b1 || o_x0 !== 16'sd1 || o_x1 !== 16'sd2) begin
      n_errors++;
      $display("FAIL busy_restart: busy=%b x0=%0d x1=%0d want 1,1,2",
               o_busy, o_x0, o_x1);
    end
    collect(-1, 0, 1'b0);
    n_checks++;
    if (q_x.size() != 4 || q_x[0] != 1 || q_y[0] != 1 ||
        q_x[3] != 2 || q_y[3] != 2) begin
      n_errors++;
      $display("FAIL busy_restart_seq: got %0d xfers want 4 from (1,1) to (2,2)",
               q_x.size());
    end
    tick();
  endtask

  task automatic test_reset_mid;
    start_tri(0, 0, 3, 0, 0, 2);
    tick();
    tick();
    tick();
    #3;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_p_x, o_p_y, o_valid, o_busy, o_done,
         o_x0, o_y0, o_x1, o_y1, o_x2, o_y2} !== 131'd0) begin
      n_errors++;
      $display("FAIL rstmid_clear: p=(%0d,%0d) v=%b b=%b d=%b x1=%0d want all 0",
               o_p_x, o_p_y, o_valid, o_busy, o_done, o_x1);
    end
    tick();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    n_checks++;
    if ({o_done, o_busy, o_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL rstmid_nodone: done,busy,valid got %b want 000",
               {o_done, o_busy, o_valid});
    end
    start_tri(1, 1, 2, 1, 1, 2);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (first_valid != 1 || q_x.size() != 4 || q_x[0] != 1 || q_y[0] != 1 ||
        q_x[1] != 2 || q_y[1] != 1 || q_x[2] != 1 || q_y[2] != 2) begin
      n_errors++;
      $display("FAIL rstmid_restart: first@%0d xfers=%0d want 1,4 from (1,1)",
               first_valid, q_x.size());
    end
    tick();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    test_basic();
    test_stall();
    test_clip();
    test_offscreen();
    test_start_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
